// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    // Frame header carries a little-endian word count of this many bytes.
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    localparam int LEN_W  = 8 * HDR_BYTES;
    localparam int LANE_W = $clog2(BYTES_PER_WORD);
    localparam int WORD_W = 8 * BYTES_PER_WORD;

    // States in which the loader is inside a frame and takes every offered byte.
    function automatic logic frame_open(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
    endfunction

    // States from which a Start pulse begins a new load.
    function automatic logic start_allowed(input state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles payload bytes, least significant first, into 32-bit words.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              take,
    input  logic [7:0]        byte_in,
    output logic              lane_last,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [LANE_W-1:0]   lane;
    logic [WORD_W-9:0]   partial;

    assign lane_last = (lane == LANE_W'(BYTES_PER_WORD - 1));

    // Shift bytes in from the top; on the final lane publish the word for one cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values; blocking here would order-couple the updates.
        if (!rst_n) begin
            lane       <= '0;
            partial    <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane    <= '0;
                partial <= '0;
            end else if (take) begin
                partial <= {byte_in, partial[WORD_W-9:8]};
                lane    <= lane + 1'b1;
                if (lane_last) begin
                    word       <= {byte_in, partial};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes words into instruction RAM,
// and keeps the CPU in reset until a frame with a good checksum has been loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemData,
    output logic              MemWE,
    output logic              CpuHold,
    output logic              Done,
    output logic              Error
);

    // Largest legal word count: the full RAM depth.
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [16:0]        word_cnt;
    logic [7:0]         xor_q;
    logic [ADDR_W-1:0]  addr_q;

    logic               xfer;
    logic               start_go;
    logic               lane_last;
    logic               word_valid;
    logic [WORD_W-1:0]  word;
    logic [16:0]        frame_len;

    assign xfer      = ByteValid && ByteReady;
    assign start_go  = Start && start_allowed(state);
    assign frame_len = {1'b0, ByteIn, len_q[7:0]};

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (Reset),
        .clear      (start_go),
        .take       (xfer && (state == DATA)),
        .byte_in    (ByteIn),
        .lane_last  (lane_last),
        .word_valid (word_valid),
        .word       (word)
    );

    // The packer's registered strobe and word drive the RAM port directly.
    assign MemWE   = word_valid;
    assign MemData = word;
    assign MemAddr = addr_q;

    // Address advances after each write strobe, so the strobe cycle shows the word's own address.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            addr_q <= '0;
        end else if (start_go) begin
            addr_q <= '0;
        end else if (word_valid) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    // Frame FSM with word counter, running XOR and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state     <= IDLE;
            len_q     <= '0;
            word_cnt  <= '0;
            xor_q     <= '0;
            ByteReady <= 1'b0;
            CpuHold   <= 1'b1;
            Done      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start_go) begin
                        state     <= LEN_LO;
                        word_cnt  <= '0;
                        xor_q     <= '0;
                        ByteReady <= 1'b1;
                        CpuHold   <= 1'b1;
                        Done      <= 1'b0;
                        Error     <= 1'b0;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= ByteIn;
                        state      <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_q <= frame_len[LEN_W-1:0];
                        if (frame_len > DEPTH) begin
                            state     <= ERR;
                            ByteReady <= 1'b0;
                            Error     <= 1'b1;
                        end else if (frame_len == '0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        xor_q <= xor_q ^ ByteIn;
                        if (lane_last) begin
                            word_cnt <= word_cnt + 1'b1;
                            if ((word_cnt + 1'b1) == {1'b0, len_q}) begin
                                state <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        ByteReady <= 1'b0;
                        if (ByteIn == xor_q) begin
                            state   <= DONE;
                            Done    <= 1'b1;
                            CpuHold <= 1'b0;
                        end else begin
                            state <= ERR;
                            Error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    ByteReady <= 1'b0;
                end
            endcase
            // An open frame never backpressures; keep the registered flag consistent with that.
            if (frame_open(state) && !xfer && !start_go) begin
                ByteReady <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a driver issues frames and pushes expected RAM
// writes into a queue; an independent monitor pops and compares on every MemWE.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              Reset;
    logic              Start;
    logic [7:0]        ByteIn;
    logic              ByteValid;
    logic              ByteReady;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemData;
    logic              MemWE;
    logic              CpuHold;
    logic              Done;
    logic              Error;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Start     (Start),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .MemAddr   (MemAddr),
        .MemData   (MemData),
        .MemWE     (MemWE),
        .CpuHold   (CpuHold),
        .Done      (Done),
        .Error     (Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               mon_e;
    int                n_checks = 0;
    int                n_pass   = 0;
    int                we_count = 0;
    int                gap_max  = 0;
    logic [7:0]        xor_model;
    logic [ADDR_W-1:0] addr_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (MemWE === 1'b1) begin
            we_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", MemAddr, MemData);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(MemAddr), 32'(mon_e.addr));
                check("write_data", MemData, mon_e.data);
            end
        end
    end

    // Offer one byte (after an optional random gap); returns 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        int w   = 0;
        repeat (gap) begin
            @(negedge clk);
            ByteValid = 1'b0;
        end
        @(negedge clk);
        ByteIn    = b;
        ByteValid = 1'b1;
        while (ByteReady !== 1'b1 && w < 16) begin
            @(negedge clk);
            w++;
        end
        if (ByteReady !== 1'b1) begin
            n_checks++;
            $display("FAIL ready_timeout: ByteReady %b, required 1", ByteReady);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] wd);
        exp_q.push_back('{addr: addr_model, data: wd});
        addr_model = addr_model + 1'b1;
        for (int i = 0; i < 4; i++) begin
            xor_model = xor_model ^ wd[8*i +: 8];
            send_byte(wd[8*i +: 8]);
        end
    endtask

    task automatic begin_frame(input logic [15:0] n);
        xor_model  = 8'h00;
        addr_model = '0;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ByteValid = 1'b0;
        Start     = 1'b1;
        @(negedge clk);
        Start     = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(ByteReady), 32'd0);
        check({tag, "_addr"},  32'(MemAddr),   32'd0);
        check({tag, "_data"},  MemData,        32'd0);
        check({tag, "_we"},    32'(MemWE),     32'd0);
        check({tag, "_hold"},  32'(CpuHold),   32'd1);
        check({tag, "_done"},  32'(Done),      32'd0);
        check({tag, "_error"}, 32'(Error),     32'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: time limit reached, required self-termination");
        $fatal(1, "watchdog");
    end

    int we0;

    initial begin
        Reset     = 1'b0;
        Start     = 1'b0;
        ByteIn    = 8'h00;
        ByteValid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        Reset = 1'b1;

        // Two-word frame, back-to-back bytes, good checksum 0x44.
        pulse_start();
        check("t1_ready_after_start", 32'(ByteReady), 32'd1);
        begin_frame(16'd2);
        send_word(32'h1122_3344);
        check("t1_we_strobe", 32'(MemWE), 32'd1);
        check("t1_we_addr0", 32'(MemAddr), 32'd0);
        send_word(32'hAABB_CCDD);
        check("t1_done_early", 32'(Done), 32'd0);
        send_byte(8'h44);
        check("t1_done", 32'(Done), 32'd1);
        check("t1_hold", 32'(CpuHold), 32'd0);
        check("t1_error", 32'(Error), 32'd0);
        check("t1_ready_off", 32'(ByteReady), 32'd0);
        check("t1_pending", 32'(exp_q.size()), 32'd0);

        // Same frame, bad checksum 0x45; Start after DONE reasserts hold.
        pulse_start();
        check("t2_hold_restart", 32'(CpuHold), 32'd1);
        check("t2_done_cleared", 32'(Done), 32'd0);
        begin_frame(16'd2);
        send_word(32'h1122_3344);
        send_word(32'hAABB_CCDD);
        send_byte(8'h45);
        check("t2_error", 32'(Error), 32'd1);
        check("t2_done", 32'(Done), 32'd0);
        check("t2_hold", 32'(CpuHold), 32'd1);
        check("t2_pending", 32'(exp_q.size()), 32'd0);

        // Empty frame: 00 00 00.
        pulse_start();
        we0 = we_count;
        begin_frame(16'd0);
        send_byte(8'h00);
        check("t3_done", 32'(Done), 32'd1);
        check("t3_no_write", 32'(we_count), 32'(we0));

        // Oversize N = 257.
        pulse_start();
        we0 = we_count;
        begin_frame(16'h0101);
        check("t4_error", 32'(Error), 32'd1);
        check("t4_ready_off", 32'(ByteReady), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_ready_stays_off", 32'(ByteReady), 32'd0);
        check("t4_no_write", 32'(we_count), 32'(we0));

        // Gapped stream with a Start pulse mid-frame that must be ignored.
        pulse_start();
        gap_max = 5;
        begin_frame(16'd2);
        send_word(32'h1122_3344);
        @(negedge clk);
        ByteValid = 1'b0;
        Start     = 1'b1;
        @(negedge clk);
        Start     = 1'b0;
        check("t5_start_ignored", 32'(ByteReady), 32'd1);
        send_word(32'hAABB_CCDD);
        send_byte(8'h44);
        check("t5_done", 32'(Done), 32'd1);
        check("t5_hold", 32'(CpuHold), 32'd0);
        check("t5_pending", 32'(exp_q.size()), 32'd0);
        gap_max = 0;

        // Reset after the 6th byte; the first write has already been issued.
        pulse_start();
        begin_frame(16'd2);
        send_word(32'h1122_3344);
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        check_reset_values("t6_midreset");
        check("t6_pending", 32'(exp_q.size()), 32'd0);
        pulse_start();
        begin_frame(16'd2);
        send_word(32'h1122_3344);
        send_word(32'hAABB_CCDD);
        send_byte(8'h44);
        check("t6_done", 32'(Done), 32'd1);
        check("t6_pending_after", 32'(exp_q.size()), 32'd0);

        // Full-depth frame (N = 256): last write lands at address 255.
        pulse_start();
        begin_frame(16'h0100);
        for (int i = 0; i < 256; i++) begin
            send_word({8'(i) ^ 8'h5A, 8'(i), 8'hC3, ~8'(i)});
        end
        send_byte(xor_model);
        check("t7_done", 32'(Done), 32'd1);
        check("t7_error", 32'(Error), 32'd0);
        check("t7_pending", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
